mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the instruction-fetch requester (IF) and the data-memory requester (D).
- Sits between the IF/MEM stages and the unified RAM, replacing their separate memory instances.
- Accepts one transaction at a time, sequences it through a fixed-latency memory access and returns the response to the granted requester.
- Uses round-robin on conflict and supports dropping an in-flight fetch on branch flush.

Parameters:
- WIDTH, 32, data and address width.
- MEM_LAT, 1, memory read latency in cycles from the issue edge to rdata valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req_valid  in  1  IF read request.
- if_req_ready  out  1  IF request accepted this cycle.
- if_addr  in  WIDTH  IF read address.
- if_flush  in  1  discard the response of an in-flight IF transaction.
- if_rsp_valid  out  1  one-cycle pulse; if_rsp_data valid.
- if_rsp_data  out  WIDTH  fetched word.
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data request accepted this cycle.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  WIDTH  data address.
- d_wdata  in  WIDTH  write data.
- d_rsp_valid  out  1  one-cycle pulse; read data or write acknowledge.
- d_rsp_data  out  WIDTH  read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  WIDTH  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory read data, valid MEM_LAT cycles after the issue edge.
- busy  out  1  state != IDLE.

Behaviour:

Reset (rst=0, asynchronous):
- State = IDLE, last_grant = IF, drop = 0, wait counter = 0.
- All outputs 0: rsp_valid, rsp_data registers, mem_en/we/addr/wdata, busy.
- An in-flight transaction is abandoned; no response is produced after release.

States:
- IDLE
  - grant_d = d_req_valid & (~if_req_valid | last_grant==IF).
  - grant_if = if_req_valid & ~grant_d.
  - ready outputs are combinational: if_req_ready = IDLE & grant_if; d_req_ready = IDLE & grant_d.
  - On valid&ready: register addr/we/wdata and the owner, update last_grant, go to ISSUE.
  - Requesters must not make valid depend on ready.
- ISSUE (one cycle)
  - mem_en = 1, mem_we = registered we (always 0 for IF), mem_addr/mem_wdata from registers.
  - Load counter = MEM_LAT, go to WAIT.
  - mem_en/mem_we are 0 in every other state; mem_addr/mem_wdata hold their last value.
- WAIT
  - Decrement the counter each cycle. When counter == 1, capture mem_rdata into the owner's rsp_data (reads only) and go to IDLE.
  - The owner's rsp_valid is registered, so it is high for exactly one cycle, which is the first IDLE cycle.

Timing and throughput:
- Handshake cycle T → mem_en in T+1 → rsp_valid in T+MEM_LAT+2.
- A new request may be accepted in the same cycle as rsp_valid.
- One transaction per MEM_LAT+2 cycles.

Writes:
- The memory write occurs at the ISSUE edge.
- d_rsp_valid pulses at the same latency as a read; d_rsp_data keeps its previous value.

Flush:
- if_flush=1 in any cycle from the IF handshake cycle through the final WAIT cycle of an IF-owned transaction sets drop.
- When drop is set: if_rsp_valid is suppressed and if_rsp_data is unchanged.
- The memory access still completes. drop clears on the return to IDLE.
- if_flush has no effect when IF owns nothing.

Other rules:
- rsp_data registers hold their value until the next capture for that requester.
- last_grant changes only on a handshake. A lone requester is always granted regardless of last_grant.

Test Plan:
- MEM_LAT=1; IF read addr 0x10 accepted cycle 0, mem_rdata=0xDEADBEEF → mem_en=1/mem_we=0/mem_addr=0x10 in cycle 1; if_rsp_valid=1 with if_rsp_data=0xDEADBEEF in cycle 3 only.
- After reset, if_req_valid and d_req_valid both high from cycle 0 → d_req_ready cycle 0; if_req_ready=0 until cycle 3; d_rsp_valid cycle 3; IF accepted cycle 3; if_rsp_valid cycle 6; next conflict grants D.
- D write d_addr=0x20, d_wdata=0x55 → mem_we=1, mem_wdata=0x55 in cycle 1; d_rsp_valid cycle 3 with d_rsp_data unchanged; back-to-back writes accepted every 3 cycles.
- IF read accepted cycle 0, if_flush=1 in cycle 2 → mem_en still pulses in cycle 1; no if_rsp_valid; busy=0 in cycle 3; next IF request accepted normally.
- MEM_LAT=3, D read → busy high cycles 1–4; d_rsp_valid cycle 5 carrying the mem_rdata present in cycle 4.
- rst low during WAIT (cycle 2) → all outputs 0 immediately; after release, no rsp_valid and state IDLE; a new request is accepted the next cycle with IF-first conflict rule reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous RAM between the instruction-fetch
// requester (IF) and the data-memory requester (D). One transaction is in
// flight at a time: it is accepted in IDLE, issued to the RAM for one cycle
// (ISSUE), and waits MEM_LAT cycles for read data (WAIT). The response is a
// registered one-cycle pulse that lands in the first IDLE cycle afterwards.
//
// Handshake: a request transfers on any rising edge where valid and ready are
// both high. Ready is combinational from valid, the arbitration state and the
// FSM state, so a requester must never make valid depend on ready.
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   if_req_valid/ready    IF read request handshake, address on if_addr
//   if_flush              drops the response of an in-flight IF transaction
//   if_rsp_valid/data     IF response pulse and fetched word
//   d_req_valid/ready     D request handshake; d_we, d_addr, d_wdata
//   d_rsp_valid/data      D response pulse (read data or write ack)
//   mem_en/we/addr/wdata  RAM command, live only during ISSUE
//   mem_rdata             RAM read data, valid MEM_LAT cycles after issue
//   busy                  high whenever the FSM is not in IDLE
//   dbg_state             FSM state for external observation
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int MEM_LAT = 1     // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req_valid,
  output logic             if_req_ready,
  input  logic [WIDTH-1:0] if_addr,
  input  logic             if_flush,
  output logic             if_rsp_valid,
  output logic [WIDTH-1:0] if_rsp_data,
  input  logic             d_req_valid,
  output logic             d_req_ready,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_rsp_valid,
  output logic [WIDTH-1:0] d_rsp_data,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] LAT4 = 4'(MEM_LAT);

  state_t     state;
  state_t     state_nx;
  logic       last_grant_d;  // 0 = IF granted last, 1 = D granted last
  logic       owner_d;       // owner of the current transaction
  logic       we_r;
  logic       drop;
  logic [3:0] cnt;

  logic       grant_d;
  logic       grant_if;
  logic       handshake;
  logic       last_wait;
  logic       flush_hit;

  // Round robin only matters on conflict: a lone requester always wins.
  assign grant_d   = d_req_valid & (~if_req_valid | ~last_grant_d);
  assign grant_if  = if_req_valid & ~grant_d;
  assign handshake = (state == S_IDLE) & (grant_d | grant_if);
  assign last_wait = (state == S_WAIT) & (cnt == 4'd1);

  // A flush counts from the IF handshake cycle up to the final WAIT cycle of
  // an IF-owned transaction; outside that window IF owns nothing.
  assign flush_hit = if_flush &
                     (((state == S_IDLE) & grant_if) |
                      ((state != S_IDLE) & ~owner_d));

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, ready and RAM strobes
  always_comb begin
    state_nx     = state;
    if_req_ready = 1'b0;
    d_req_ready  = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    case (state)
      S_IDLE: begin
        if_req_ready = grant_if;
        d_req_ready  = grant_d;
        if (grant_if | grant_d) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        mem_en   = 1'b1;
        mem_we   = we_r;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == 4'd1) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Transaction registers, latency counter and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_d <= 1'b0;
      owner_d      <= 1'b0;
      we_r         <= 1'b0;
      drop         <= 1'b0;
      cnt          <= 4'd0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_valid  <= 1'b0;
      d_rsp_data   <= '0;
    end else begin
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;

      // mem_addr/mem_wdata double as the request registers, so they simply
      // hold their last value outside ISSUE.
      if (handshake) begin
        owner_d      <= grant_d;
        last_grant_d <= grant_d;
        if (grant_d) begin
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          we_r      <= d_we;
        end else begin
          mem_addr  <= if_addr;
          we_r      <= 1'b0;
        end
      end

      if (state == S_ISSUE) begin
        cnt <= LAT4;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end

      if (last_wait) begin
        if (owner_d) begin
          d_rsp_valid <= 1'b1;
          if (!we_r) d_rsp_data <= mem_rdata;
        end else if (!(drop | if_flush)) begin
          // A flush in the final WAIT cycle still has to suppress the
          // response, hence the direct look at if_flush here.
          if_rsp_valid <= 1'b1;
          if_rsp_data  <= mem_rdata;
        end
        drop <= 1'b0;
      end else if (flush_hit) begin
        drop <= 1'b1;
      end
    end
  end

endmodule
